mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's load/store path.
- Accepts one request at a time over a valid/ready handshake: byte address, read/write, access size, write data.
- Performs the access against an internal word array after a fixed number of wait states.
- Returns read data plus an error flag on a one-cycle response strobe.
- Intended to replace the zero-wait memory when the control unit is extended with wait-state handling.

Parameters:
- ADDR_W, 8, word-index bits; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 = word, 01 = half, 10 = byte, 11 = reserved (treated as error)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data, zero-extended, right-aligned; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned, out-of-range or reserved size

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - req_ready = 1 in the cycle after reset
  - array contents are not cleared.
- Handshake: a request transfers on a rising edge where req_valid && req_ready. At that edge, addr, wr, size and wdata are captured into holding registers. Inputs are don't-care afterwards.
- FSM:
  - IDLE: req_ready = 1. On transfer, go to WAIT with cnt = LATENCY-1, or go directly to ACCESS if LATENCY = 0.
  - WAIT: req_ready = 0. cnt decrements each cycle; when cnt = 0, go to ACCESS.
  - ACCESS: req_ready = 0.
    - Check the request: misaligned if size = word with addr[1:0] != 0, or size = half with addr[0] = 1; out-of-range if addr[31:ADDR_W+2] != 0; reserved size = 11.
    - If the check fails: no array write, rsp_rdata = 0, rsp_err = 1.
    - Otherwise a store commits its lane-masked write on this edge, and a load registers its lane data.
    - Next state is RESP.
  - RESP: rsp_valid = 1 for exactly this cycle; req_ready = 0; next state is IDLE.
- Latency: accept edge to rsp_valid high is LATENCY+2 cycles. Back-to-back requests are spaced LATENCY+3 cycles apart.
- Byte lanes (big-endian):
  - byte at addr[1:0] = 0 maps to word bits [31:24]; addr[1:0] = 3 maps to [7:0].
  - half at addr[1] = 0 maps to [31:16].
  - Stores update only the selected lanes; unselected bytes are preserved.
- Loads of a word written in an earlier transaction return the committed value; there is no same-transaction read-modify hazard.
- rsp_rdata and rsp_err hold their last value outside RESP; consumers sample them only with rsp_valid.
- Reset mid-operation:
  - A request in WAIT is dropped: no write, no response.
  - A write already committed in ACCESS persists.
  - Reset asserted during RESP forces rsp_valid = 0 on the next edge.
- req_valid asserted while req_ready = 0 is ignored; the requester must hold it.

Optional Feature:
- Macro: MEM_RESP_OVERLAP_EN.
- When defined: req_ready = 1 also in RESP. A transfer in RESP moves the FSM directly to WAIT/ACCESS instead of IDLE. Back-to-back spacing becomes LATENCY+2 cycles.
- When undefined: behaviour exactly as above.

Decomposition:
- Package mem_resp_pkg:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD
  - FSM state typedef (IDLE, WAIT, ACCESS, RESP)
  - function for the lane mask (size, addr[1:0]) -> 4-bit byte-enable
- Sub-module mem_resp_array: 2**ADDR_W x 32 storage with 4-bit byte-enable write port and registered read port. The FSM and error check stay in mem_responder.

Test Plan:
- Word store then load, LATENCY = 2: store 0xDEADBEEF @0x10 -> rsp_err 0 at accept+4. Load @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0.
- Byte/half lanes: store byte 0xAA @0x13 over 0x11223344 -> word reads 0x112233AA. Load half @0x12 -> 0x000033AA. Load byte @0x10 -> 0x00000011.
- Errors: load word @0x12, store half @0x21, and access @0x400 with ADDR_W = 8 -> each gives rsp_err 1, rsp_rdata 0. A following word read confirms memory is unchanged.
- Handshake timing: LATENCY = 0 and LATENCY = 15 -> rsp_valid exactly 2 and 17 cycles after accept, high one cycle. req_ready low from accept+1 to the end of RESP. Requests held during busy are accepted the cycle after RESP.
- Reset mid-WAIT: store 0x5 @0x8, then reset during WAIT -> no rsp_valid. Read @0x8 returns the prior contents.
- Overlap (MEM_RESP_OVERLAP_EN, LATENCY = 1): request presented in RESP is accepted -> second rsp_valid 3 cycles after the first.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and helpers for the memory responder:
//   - access size encodings (size_e)
//   - responder FSM states (state_e)
//   - lane_mask   : (size, addr[1:0]) -> big-endian 4-bit byte enable
//   - store_lanes : replicate right-aligned store data onto every lane
//   - load_extract: pick the addressed lanes of a word, zero-extended
// Byte enable bit b covers word bits [8*b+7:8*b]; byte offset 0 is the MSB
// lane (big-endian).
// ---------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: be = 4'b1000 >> off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // The byte enable selects which copy actually lands, so replication
  // avoids a shifter on the write path.
  function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      SZ_WORD: lanes = wd;
      SZ_HALF: lanes = {2{wd[15:0]}};
      default: lanes = {4{wd[7:0]}};
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extract(input size_e size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] res;
    res = 32'h0;
    case (size)
      SZ_WORD: res = word;
      SZ_HALF: res = off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
      SZ_BYTE: begin
        case (off)
          2'd0:    res = {24'h0, word[31:24]};
          2'd1:    res = {24'h0, word[23:16]};
          2'd2:    res = {24'h0, word[15:8]};
          default: res = {24'h0, word[7:0]};
        endcase
      end
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// ---------------------------------------------------------------------------
// mem_resp_array
// 2**ADDR_W x 32-bit storage, single address port.
//   clk        : clock
//   reset      : synchronous active-high, clears only the read register
//   wr_be_i    : per-byte write enable (bit b -> bits [8b+7:8b])
//   addr_i     : word index
//   wdata_i    : write data, already placed on its lanes
//   rd_en_i    : capture mem[addr_i] into the read register
//   rdata_o    : registered read data
// Storage contents are never cleared.
// ---------------------------------------------------------------------------
module mem_resp_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        wr_be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              rd_en_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU load/store path: one outstanding request,
// fixed LATENCY wait states, one-cycle response strobe.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_wr              : 1 = store, 0 = load
//   req_size            : 00 word, 01 half, 10 byte, 11 reserved (error)
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata           : zero-extended load data (0 for stores / errors)
//   rsp_err             : misaligned, out-of-range or reserved size
// Optional build macro MEM_RESP_OVERLAP_EN: accept the next request while in
// RESP, saving one cycle between back-to-back requests.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting wait states down to zero
// ACCESS | check request, commit store or read array
// RESP   | rsp_valid high for one cycle
// ---------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam state_e     START_ST = (LATENCY == 0) ? ACCESS : WAIT;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // request holding registers, loaded on transfer
  logic [31:0] addr_q;
  logic        wr_q;
  size_e       size_q;
  logic [31:0] wdata_q;

  // response registers, loaded in ACCESS so they hold until the next ACCESS
  logic        err_q;
  logic        load_q;
  size_e       rsz_q;
  logic [1:0]  roff_q;

  logic        accept;
  logic        in_access;
  logic        misaligned, out_of_range, reserved, acc_err;
  logic [3:0]  arr_be;
  logic        arr_rd_en;
  logic [31:0] arr_rdata;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = START_ST;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
`ifdef MEM_RESP_OVERLAP_EN
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = START_ST;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // request check against the held request, used only in ACCESS
  always_comb begin
    misaligned   = ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)) ||
                   ((size_q == SZ_HALF) && addr_q[0]);
    out_of_range = (addr_q >> (ADDR_W + 2)) != 32'h0;
    reserved     = (size_q == SZ_RSVD);
    acc_err      = misaligned || out_of_range || reserved;
  end

  assign in_access = (state_q == ACCESS);
  assign arr_be    = (in_access && wr_q && !acc_err) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
  assign arr_rd_en = in_access && !wr_q && !acc_err;

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_be_i (arr_be),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (store_lanes(size_q, wdata_q)),
    .rd_en_i (arr_rd_en),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wr_q    <= 1'b0;
      size_q  <= SZ_WORD;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      rsz_q   <= SZ_WORD;
      roff_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wr_q    <= req_wr;
        size_q  <= size_e'(req_size);
        wdata_q <= req_wdata;
      end
      if (in_access) begin
        err_q  <= acc_err;
        load_q <= !wr_q;
        rsz_q  <= size_q;
        roff_q <= addr_q[1:0];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  // array read register only updates on good loads; the mask keeps stores
  // and errors reading back as zero
  assign rsp_rdata = (err_q || !load_q) ? 32'h0 : load_extract(rsz_q, roff_q, arr_rdata);

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Four responder instances sharing one clock: LATENCY 2, 0, 15 and 1.
// Directed steps with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int LIM = 40;
  localparam int LATS [4] = '{2, 0, 15, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0]       req_wr;
  logic [3:0][1:0]  req_size;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_wdata;
  logic [3:0]       rsp_valid;
  logic [3:0][31:0] rsp_rdata;
  logic [3:0]       rsp_err;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .ADDR_W  (8),
      .LATENCY (LATS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wr    (req_wr[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  // side observations of the last transaction
  int   busy_rdy;
  logic resp_rdy;
  logic vld_after;

`ifdef MEM_RESP_OVERLAP_EN
  localparam logic RESP_RDY_EXP = 1'b1;
  localparam int   HOLD_ACC_EXP = 3;
`else
  localparam logic RESP_RDY_EXP = 1'b0;
  localparam int   HOLD_ACC_EXP = 4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call and return at a negedge. lat counts cycles from the accept cycle to
  // the cycle where rsp_valid is seen high.
  task automatic xact(input int d, input logic wr, input size_e sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    req_wr[d]    = wr;
    req_size[d]  = sz;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'hFFFF_FFFF;
    req_size[d]  = 2'b11;
    lat      = 1;
    busy_rdy = 0;
    while (rsp_valid[d] !== 1'b1 && lat < LIM) begin
      if (req_ready[d] !== 1'b0) busy_rdy++;
      @(negedge clk);
      lat++;
    end
    rd       = rsp_rdata[d];
    er       = rsp_err[d];
    resp_rdy = req_ready[d];
    @(negedge clk);
    vld_after = rsp_valid[d];
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          first_rsp, second_acc, second_rsp, seen;
  logic [31:0] b_rd;

  initial begin
    reset     = 4'hF;
    req_valid = '0;
    req_wr    = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 4'h0;
    @(negedge clk);

    // reset state
    for (int d = 0; d < 4; d++) chk("rst_ready", 32'(req_ready[d]), 32'd1);
    chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_err",   32'(rsp_err[0]),   32'd0);
    chk("rst_rdata", rsp_rdata[0],      32'h0);

    // word store / load, LATENCY 2
    xact(0, 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_word_lat", 32'(lat), 32'd4);
    chk("st_word_err", 32'(er), 32'd0);
    chk("st_word_rd",  rd, 32'h0);
    xact(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
    chk("ld_word_rd",  rd, 32'hDEADBEEF);
    chk("ld_word_err", 32'(er), 32'd0);

    // byte / half lanes
    xact(0, 1'b1, SZ_WORD, 32'h10, 32'h11223344, rd, er, lat);
    xact(0, 1'b1, SZ_BYTE, 32'h13, 32'hFFFFFFAA, rd, er, lat);
    chk("st_byte_err", 32'(er), 32'd0);
    xact(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
    chk("byte_merge", rd, 32'h112233AA);
    xact(0, 1'b0, SZ_HALF, 32'h12, 32'h0, rd, er, lat);
    chk("ld_half_12", rd, 32'h000033AA);
    xact(0, 1'b0, SZ_BYTE, 32'h10, 32'h0, rd, er, lat);
    chk("ld_byte_10", rd, 32'h00000011);
    xact(0, 1'b1, SZ_HALF, 32'h10, 32'h1234BEEF, rd, er, lat);
    xact(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
    chk("half_merge", rd, 32'hBEEF33AA);
    xact(0, 1'b0, SZ_BYTE, 32'h11, 32'h0, rd, er, lat);
    chk("ld_byte_11", rd, 32'h000000EF);
    xact(0, 1'b0, SZ_HALF, 32'h10, 32'h0, rd, er, lat);
    chk("ld_half_10", rd, 32'h0000BEEF);

    // errors
    xact(0, 1'b1, SZ_WORD, 32'h20, 32'hCAFEF00D, rd, er, lat);
    xact(0, 1'b0, SZ_WORD, 32'h12, 32'h0, rd, er, lat);
    chk("mis_word_err", 32'(er), 32'd1);
    chk("mis_word_rd",  rd, 32'h0);
    xact(0, 1'b1, SZ_HALF, 32'h21, 32'hFFFFFFFF, rd, er, lat);
    chk("mis_half_err", 32'(er), 32'd1);
    chk("mis_half_lat", 32'(lat), 32'd4);
    xact(0, 1'b0, SZ_WORD, 32'h20, 32'h0, rd, er, lat);
    chk("mis_half_keep", rd, 32'hCAFEF00D);
    xact(0, 1'b1, SZ_WORD, 32'h0, 32'hA5A5A5A5, rd, er, lat);
    xact(0, 1'b1, SZ_WORD, 32'h400, 32'h12345678, rd, er, lat);
    chk("oor_st_err", 32'(er), 32'd1);
    xact(0, 1'b0, SZ_WORD, 32'h400, 32'h0, rd, er, lat);
    chk("oor_ld_err", 32'(er), 32'd1);
    chk("oor_ld_rd",  rd, 32'h0);
    xact(0, 1'b0, SZ_WORD, 32'h0, 32'h0, rd, er, lat);
    chk("oor_keep", rd, 32'hA5A5A5A5);
    xact(0, 1'b0, SZ_RSVD, 32'h10, 32'h0, rd, er, lat);
    chk("rsvd_ld_err", 32'(er), 32'd1);
    chk("rsvd_ld_rd",  rd, 32'h0);
    xact(0, 1'b1, SZ_RSVD, 32'h10, 32'h0, rd, er, lat);
    chk("rsvd_st_err", 32'(er), 32'd1);
    xact(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
    chk("rsvd_keep", rd, 32'hBEEF33AA);
    chk("rd_ok_err", 32'(er), 32'd0);

    // handshake timing, LATENCY 0
    xact(1, 1'b1, SZ_WORD, 32'h4, 32'h01020304, rd, er, lat);
    chk("l0_lat",       32'(lat), 32'd2);
    chk("l0_busy_rdy",  32'(busy_rdy), 32'd0);
    chk("l0_resp_rdy",  32'(resp_rdy), 32'(RESP_RDY_EXP));
    chk("l0_one_cycle", 32'(vld_after), 32'd0);
    xact(1, 1'b0, SZ_WORD, 32'h4, 32'h0, rd, er, lat);
    chk("l0_rd", rd, 32'h01020304);

    // handshake timing, LATENCY 15
    xact(2, 1'b1, SZ_WORD, 32'h4, 32'h0A0B0C0D, rd, er, lat);
    chk("l15_lat",       32'(lat), 32'd17);
    chk("l15_busy_rdy",  32'(busy_rdy), 32'd0);
    chk("l15_one_cycle", 32'(vld_after), 32'd0);
    xact(2, 1'b0, SZ_WORD, 32'h4, 32'h0, rd, er, lat);
    chk("l15_rd", rd, 32'h0A0B0C0D);

    // request held while busy, LATENCY 1: store A then load B of same word
    req_wr[3]    = 1'b1;
    req_size[3]  = SZ_WORD;
    req_addr[3]  = 32'h40;
    req_wdata[3] = 32'h0BADCAFE;
    req_valid[3] = 1'b1;
    chk("hold_acc_a", 32'(req_ready[3]), 32'd1);
    first_rsp  = -1;
    second_acc = -1;
    second_rsp = -1;
    b_rd       = 32'h0;
    for (int t = 1; t <= LIM; t++) begin
      @(negedge clk);
      if (t == 1) begin
        req_wr[3]    = 1'b0;
        req_wdata[3] = 32'h0;
      end
      if (second_acc >= 0) req_valid[3] = 1'b0;
      if (rsp_valid[3]) begin
        if (first_rsp < 0) first_rsp = t;
        else if (second_rsp < 0) begin
          second_rsp = t;
          b_rd       = rsp_rdata[3];
        end
      end
      if (second_acc < 0 && req_valid[3] && req_ready[3]) second_acc = t;
    end
    chk("hold_first_rsp", 32'(first_rsp), 32'd3);
    chk("hold_acc_b",     32'(second_acc), 32'(HOLD_ACC_EXP));
    chk("hold_rsp_gap",   32'(second_rsp - first_rsp), 32'(HOLD_ACC_EXP));
    chk("hold_b_rd",      b_rd, 32'h0BADCAFE);

    // reset during WAIT drops the store
    xact(0, 1'b1, SZ_WORD, 32'h8, 32'h77777777, rd, er, lat);
    req_wr[0]    = 1'b1;
    req_size[0]  = SZ_WORD;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h5;
    req_valid[0] = 1'b1;
    chk("rstw_acc", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0]     = 1'b1;
    seen = 0;
    if (rsp_valid[0]) seen++;
    @(negedge clk);
    reset[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid[0]) seen++;
      @(negedge clk);
    end
    chk("rstw_no_rsp", 32'(seen), 32'd0);
    chk("rstw_ready",  32'(req_ready[0]), 32'd1);
    xact(0, 1'b0, SZ_WORD, 32'h8, 32'h0, rd, er, lat);
    chk("rstw_keep", rd, 32'h77777777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
